axi4_lite_regfile_slave: RTL and testbench

AXI4-Lite responder holding four 32-bit software-visible registers for the RNA443 accelerator. It is the slave end of the link driven by the AXI4-Lite master BFM. It accepts write address and write data independently, applies byte strobes, and returns BRESP. Reads return the addressed register one cycle after the address handshake. Register contents and per-register write pulses are exported to the neural-network datapath.

---
 rtl/axi4_rna443_pkg.sv | 31 +++
 rtl/axi4_lite_regfile_slave_if.sv | 39 +++
 rtl/axi4_lite_strb_regbank.sv | 53 +++++
 rtl/axi4_lite_regfile_slave.sv | 167 ++++++++++++++++
 tb/tb_axi4_lite_regfile_slave.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_rna443_pkg.sv
// Shared constants, write-channel state encoding and the byte-strobe merge helper
// for the RNA443 AXI4-Lite register file.
package axi4_rna443_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;

   localparam int unsigned REG_CTRL = 0;
   localparam int unsigned REG_IN   = 1;
   localparam int unsigned REG_W    = 2;
   localparam int unsigned REG_OUT  = 3;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_A,
      W_HAVE_D,
      W_RESP
   } wstate_e;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle between the master BFM and the RNA443 register file.
interface axi4_lite_regfile_slave_if #(
   parameter int unsigned C_ADDR_WIDTH = 4,
   parameter int unsigned C_DATA_WIDTH = 32
) ();

   logic [C_ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]                AWPROT;
   logic                      AWVALID;
   logic                      AWREADY;
   logic [C_DATA_WIDTH-1:0]   WDATA;
   logic [C_DATA_WIDTH/8-1:0] WSTRB;
   logic                      WVALID;
   logic                      WREADY;
   logic [1:0]                BRESP;
   logic                      BVALID;
   logic                      BREADY;
   logic [C_ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]                ARPROT;
   logic                      ARVALID;
   logic                      ARREADY;
   logic [C_DATA_WIDTH-1:0]   RDATA;
   logic [1:0]                RRESP;
   logic                      RVALID;
   logic                      RREADY;

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/axi4_lite_strb_regbank.sv
// Register bank: byte-strobed write port with a one-cycle commit pulse per register,
// combinational read mux and a flattened view of all registers.
module axi4_lite_strb_regbank
   import axi4_rna443_pkg::*;
#(
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned IDX_W    = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   we_i,
   input  logic [IDX_W-1:0]       widx_i,
   input  logic [31:0]            wdata_i,
   input  logic [3:0]             wstrb_i,
   input  logic [IDX_W-1:0]       ridx_i,
   output logic [31:0]            rdata_o,
   output logic [NUM_REGS*32-1:0] regs_o,
   output logic [NUM_REGS-1:0]    wr_pulse_o
);

   logic [31:0]         regs_q [NUM_REGS];
   logic [31:0]         regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pulse_q, pulse_d;

   always_comb begin
      pulse_d = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (we_i && (widx_i == i[IDX_W-1:0])) begin
            regs_d[i]  = apply_strb(regs_q[i], wdata_i, wstrb_i);
            pulse_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         pulse_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[i*32 +: 32] = regs_q[i];
   end

   assign rdata_o    = regs_q[ridx_i];
   assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite responder for the four RNA443 software registers: independent AW/W capture,
// byte-strobed commit with BRESP, and one-cycle-latency reads.
module axi4_lite_regfile_slave
   import axi4_rna443_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH = 32,
   parameter int unsigned C_ADDR_WIDTH = 4,
   parameter int unsigned C_NUM_REGS   = 2 ** (C_ADDR_WIDTH - 2)
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   axi4_lite_regfile_slave_if.slave s_axi,
   output logic [C_NUM_REGS*32-1:0] reg_out,
   output logic [C_NUM_REGS-1:0]    reg_wr_pulse
);

   localparam int unsigned IDX_W = C_ADDR_WIDTH - 2;

   wstate_e          wstate_q, wstate_d;
   logic             awready_q, awready_d;
   logic             wready_q, wready_d;
   logic             bvalid_q, bvalid_d;
   logic [IDX_W-1:0] widx_q, widx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;

   logic             arready_q, arready_d;
   logic             rvalid_q, rvalid_d;
   logic [31:0]      rdata_q, rdata_d;

   logic             aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0] commit_idx;
   logic [31:0]      commit_data;
   logic [3:0]       commit_strb;
   logic [31:0]      bank_rdata;
   logic             unused_bits;

   assign aw_hs = s_axi.AWVALID && awready_q;
   assign w_hs  = s_axi.WVALID  && wready_q;
   assign ar_hs = s_axi.ARVALID && arready_q;

   // The half arriving on the commit edge is used directly; the other half comes from the latch.
   assign commit_idx  = aw_hs ? s_axi.AWADDR[C_ADDR_WIDTH-1:2] : widx_q;
   assign commit_data = w_hs  ? s_axi.WDATA : wdata_q;
   assign commit_strb = w_hs  ? s_axi.WSTRB : wstrb_q;

   always_comb begin
      wstate_d  = wstate_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      widx_d    = aw_hs ? s_axi.AWADDR[C_ADDR_WIDTH-1:2] : widx_q;
      wdata_d   = w_hs  ? s_axi.WDATA : wdata_q;
      wstrb_d   = w_hs  ? s_axi.WSTRB : wstrb_q;
      commit    = 1'b0;
      unique case (wstate_q)
         W_IDLE: begin
            awready_d = 1'b1;
            wready_d  = 1'b1;
            if (aw_hs && w_hs) begin
               commit    = 1'b1;
               bvalid_d  = 1'b1;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               wstate_d  = W_RESP;
            end else if (aw_hs) begin
               awready_d = 1'b0;
               wstate_d  = W_HAVE_A;
            end else if (w_hs) begin
               wready_d  = 1'b0;
               wstate_d  = W_HAVE_D;
            end
         end
         W_HAVE_A: begin
            awready_d = 1'b0;
            if (w_hs) begin
               commit   = 1'b1;
               bvalid_d = 1'b1;
               wready_d = 1'b0;
               wstate_d = W_RESP;
            end
         end
         W_HAVE_D: begin
            wready_d = 1'b0;
            if (aw_hs) begin
               commit    = 1'b1;
               bvalid_d  = 1'b1;
               awready_d = 1'b0;
               wstate_d  = W_RESP;
            end
         end
         W_RESP: begin
            awready_d = 1'b0;
            wready_d  = 1'b0;
            if (bvalid_q && s_axi.BREADY) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               wstate_d  = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_comb begin
      rvalid_d = rvalid_q;
      if (rvalid_q && s_axi.RREADY) rvalid_d = 1'b0;
      if (ar_hs)                    rvalid_d = 1'b1;
      arready_d = !rvalid_d;
      rdata_d   = ar_hs ? bank_rdata : rdata_q;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         widx_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         wstate_q  <= wstate_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         widx_q    <= widx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   axi4_lite_strb_regbank #(
      .NUM_REGS (C_NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .clk_i      (ACLK),
      .rst_i      (ARESET),
      .we_i       (commit),
      .widx_i     (commit_idx),
      .wdata_i    (commit_data),
      .wstrb_i    (commit_strb),
      .ridx_i     (s_axi.ARADDR[C_ADDR_WIDTH-1:2]),
      .rdata_o    (bank_rdata),
      .regs_o     (reg_out),
      .wr_pulse_o (reg_wr_pulse)
   );

   assign s_axi.AWREADY = awready_q;
   assign s_axi.WREADY  = wready_q;
   assign s_axi.BVALID  = bvalid_q;
   assign s_axi.BRESP   = RESP_OKAY;
   assign s_axi.ARREADY = arready_q;
   assign s_axi.RVALID  = rvalid_q;
   assign s_axi.RDATA   = rdata_q;
   assign s_axi.RRESP   = RESP_OKAY;

   assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Scoreboard bench for axi4_lite_regfile_slave: drivers push expected B/R responses,
// negedge monitors pop and compare them against a word-array reference model.
module tb_axi4_lite_regfile_slave;
   import axi4_rna443_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] reg_out;
   logic [3:0]   reg_wr_pulse;

   always #5 clk = ~clk;

   axi4_lite_regfile_slave_if #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) bus ();

   axi4_lite_regfile_slave #(
      .C_DATA_WIDTH (32),
      .C_ADDR_WIDTH (4),
      .C_NUM_REGS   (4)
   ) dut (
      .ACLK         (clk),
      .ARESET       (rst),
      .s_axi        (bus),
      .reg_out      (reg_out),
      .reg_wr_pulse (reg_wr_pulse)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] model [4];
   logic [1:0]  bq [$];
   logic [31:0] rq [$];
   logic [1:0]  eb;
   logic [31:0] er;

   function automatic logic [127:0] model_flat();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   // Each byte lane taken from the new word where its strobe is set.
   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.BVALID && bus.BREADY) begin
         if (bq.size() == 0) timeout_fail("b_unexpected");
         else begin
            eb = bq.pop_front();
            chk("bresp", bus.BRESP, eb);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus.RVALID && bus.RREADY) begin
         if (rq.size() == 0) timeout_fail("r_unexpected");
         else begin
            er = rq.pop_front();
            chk("rdata", bus.RDATA, er);
            chk("rresp", bus.RRESP, RESP_OKAY);
         end
      end
   end

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit with_ar,
                           input logic [3:0] ar_addr);
      int   n;
      int   ar_n;
      bit   aw_done, w_done, ar_done, aw_hit, w_hit, ar_hit;
      logic [3:0] onehot;
      @(posedge clk); #1;
      n = 0; ar_n = -1;
      aw_done = 0; w_done = 0; ar_done = !with_ar;
      bus.AWADDR  = addr;
      bus.WDATA   = data;
      bus.WSTRB   = strb;
      bus.AWVALID = (aw_dly == 0);
      bus.WVALID  = (w_dly == 0);
      if (with_ar) begin
         bus.ARADDR  = ar_addr;
         bus.ARVALID = 1'b1;
      end
      while (!(aw_done && w_done)) begin
         if (n >= 60) begin
            timeout_fail("write_handshake");
            bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
            return;
         end
         @(negedge clk);
         aw_hit = bus.AWVALID && bus.AWREADY;
         w_hit  = bus.WVALID && bus.WREADY;
         ar_hit = bus.ARVALID && bus.ARREADY && !ar_done;
         if (w_done && !aw_done) chk("wready_low_while_waiting", bus.WREADY, 1'b0);
         if (aw_done && !w_done) chk("awready_low_while_waiting", bus.AWREADY, 1'b0);
         if (ar_hit) begin
            rq.push_back(model[ar_addr[3:2]]);
            ar_n = n;
         end
         @(posedge clk); #1;
         if (aw_hit) begin bus.AWVALID = 1'b0; aw_done = 1; end
         if (w_hit)  begin bus.WVALID  = 1'b0; w_done  = 1; end
         if (ar_hit) begin bus.ARVALID = 1'b0; ar_done = 1; end
         n++;
         if (!aw_done && n >= aw_dly) bus.AWVALID = 1'b1;
         if (!w_done  && n >= w_dly)  bus.WVALID  = 1'b1;
      end
      if (with_ar) begin
         bus.ARVALID = 1'b0;
         chk("ar_on_commit_edge", ar_n, n - 1);
      end
      model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
      bq.push_back(RESP_OKAY);
      onehot = 4'b0001 << addr[3:2];
      @(negedge clk);
      chk("bvalid_after_commit", bus.BVALID, 1'b1);
      chk("wr_pulse", reg_wr_pulse, onehot);
      chk("reg_out", reg_out, model_flat());
      @(negedge clk);
      chk("wr_pulse_one_cycle", reg_wr_pulse, 4'b0000);
   endtask

   task automatic do_read(input logic [3:0] addr, output logic [31:0] exp);
      int n;
      bit hit;
      exp = '0;
      @(posedge clk); #1;
      bus.ARADDR  = addr;
      bus.ARVALID = 1'b1;
      n = 0; hit = 0;
      while (!hit) begin
         if (n >= 60) begin
            timeout_fail("read_handshake");
            bus.ARVALID = 1'b0;
            return;
         end
         @(negedge clk);
         if (bus.ARVALID && bus.ARREADY) begin
            exp = model[addr[3:2]];
            rq.push_back(exp);
            hit = 1;
         end
         @(posedge clk); #1;
         n++;
      end
      bus.ARVALID = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bq.size() == 0 && rq.size() == 0) break;
      end
      chk("responses_drained", bq.size() + rq.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] e;
      logic [31:0] wa [4];
      logic [3:0]  ra;

      rst = 1'b1;
      bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
      bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
      for (int i = 0; i < 4; i++) model[i] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", bus.AWREADY, 1'b0);
      chk("rst_wready", bus.WREADY, 1'b0);
      chk("rst_arready", bus.ARREADY, 1'b0);
      chk("rst_bvalid", bus.BVALID, 1'b0);
      chk("rst_rvalid", bus.RVALID, 1'b0);
      chk("rst_rdata", bus.RDATA, 32'h0);
      chk("rst_bresp", bus.BRESP, 2'b00);
      chk("rst_rresp", bus.RRESP, 2'b00);
      chk("rst_reg_out", reg_out, 128'h0);
      chk("rst_wr_pulse", reg_wr_pulse, 4'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("awready_after_reset", bus.AWREADY, 1'b1);
      chk("wready_after_reset", bus.WREADY, 1'b1);
      chk("arready_after_reset", bus.ARREADY, 1'b1);

      // Directed write/read-back of every register.
      wa[0] = 32'h0101FFFF; wa[1] = 32'habcd0001; wa[2] = 32'hdead0011; wa[3] = 32'hbeef0011;
      for (int i = 0; i < 4; i++) begin
         ra = 4'(i * 4);
         do_write(ra, wa[i], 4'hF, 0, 0, 0, 4'h0);
         do_read(ra, e);
      end
      drain();

      // Partial strobes on reg1.
      do_write(4'h4, 32'h11223344, 4'b0101, 0, 0, 0, 4'h0);
      do_read(4'h4, e);
      drain();

      // W leads AW by three cycles.
      do_write(4'h8, 32'hCAFEF00D, 4'hF, 3, 0, 0, 4'h0);
      do_read(4'h8, e);
      drain();

      // B back-pressure.
      bus.BREADY = 1'b0;
      do_write(4'h0, 32'h5A5A1234, 4'hF, 0, 0, 0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bstall_bvalid", bus.BVALID, 1'b1);
         chk("bstall_awready", bus.AWREADY, 1'b0);
         chk("bstall_wready", bus.WREADY, 1'b0);
      end
      @(posedge clk); #1;
      bus.BREADY = 1'b1;
      drain();
      do_write(4'h1, 32'h0BADBEEF, 4'hF, 0, 0, 0, 4'h0);

      // R back-pressure.
      bus.RREADY = 1'b0;
      do_read(4'h1, e);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstall_rvalid", bus.RVALID, 1'b1);
         chk("rstall_rdata", bus.RDATA, e);
         chk("rstall_arready", bus.ARREADY, 1'b0);
      end
      @(posedge clk); #1;
      bus.RREADY = 1'b1;
      drain();

      // Read and write of reg3 on the same edge: the read sees the old value.
      do_write(4'hC, 32'h0, 4'hF, 0, 0, 0, 4'h0);
      drain();
      do_write(4'hC, 32'h55, 4'hF, 0, 0, 1, 4'hC);
      drain();
      do_read(4'hC, e);
      drain();

      // Randomized traffic, including unaligned addresses and empty strobes.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            do_write(4'($urandom_range(15, 0)), $urandom,
                     ($urandom_range(4, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0)),
                     $urandom_range(3, 0), $urandom_range(3, 0), 0, 4'h0);
         end else begin
            do_read(4'($urandom_range(15, 0)), e);
         end
      end
      drain();

      // Reset while an address is held without data.
      do_write(4'h0, 32'h1234, 4'hF, 0, 0, 0, 4'h0);
      drain();
      @(posedge clk); #1;
      bus.AWADDR  = 4'h0;
      bus.AWVALID = 1'b1;
      @(negedge clk);
      chk("held_aw_accepted", bus.AWREADY, 1'b1);
      @(posedge clk); #1;
      bus.AWVALID = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      @(negedge clk);
      chk("post_rst_bvalid", bus.BVALID, 1'b0);
      chk("post_rst_reg_out", reg_out, 128'h0);
      @(negedge clk);
      chk("post_rst_awready", bus.AWREADY, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_b", bus.BVALID, 1'b0);
         chk("post_rst_no_pulse", reg_wr_pulse, 4'h0);
      end
      do_read(4'h0, e);
      do_write(4'h4, 32'h77665544, 4'hF, 0, 0, 0, 4'h0);
      do_read(4'h4, e);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
